// File: rtl/rv_decode_pkg.sv
// ============================================================================
// rv_decode_pkg: opcodes, format enum, decoded bundle and immediate builder
// Revision: 1.0
// ============================================================================
`default_nettype none

package rv_decode_pkg;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;
    fmt_e       fmt;
    logic       illegal;
  } decoded_t;

  // Always builds the 64-bit sign-extended form; narrower datapaths truncate.
  function automatic logic [63:0] imm_gen(input logic [31:0] instr, input fmt_e fmt);
    logic [63:0] imm;
    imm = '0;
    case (fmt)
      FMT_I:   imm = {{52{instr[31]}}, instr[31:20]};
      FMT_S:   imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm = {{32{instr[31]}}, instr[31:12], 12'b0};
      FMT_J:   imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv_imm_gen.sv
// ============================================================================
// rv_imm_gen: combinational format classification, immediate and illegal flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module rv_imm_gen
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output fmt_e            fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  always_comb begin
    fmt     = FMT_R;
    illegal = 1'b0;
    if (instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (instr[6:0])
        OP_OP:                                              fmt = FMT_R;
        OP_LOAD, OP_OP_IMM, OP_JALR, OP_SYSTEM, OP_MISC_MEM: fmt = FMT_I;
        OP_STORE:                                           fmt = FMT_S;
        OP_BRANCH:                                          fmt = FMT_B;
        OP_LUI, OP_AUIPC:                                   fmt = FMT_U;
        OP_JAL:                                             fmt = FMT_J;
        default:                                            illegal = 1'b1;
      endcase
    end
  end

  // Illegal encodings fall back to FMT_R, which yields a zero immediate.
  assign imm = XLEN'(imm_gen(instr, fmt));

endmodule

`default_nettype wire

// File: rtl/rv_decode_stage.sv
// ============================================================================
// rv_decode_stage: registered decode stage with valid/ready, stall and flush.
// Optional build macro RV_DECODE_SKID_EN adds a 1-entry skid (registered in_ready).
// Revision: 1.0
// ============================================================================
`default_nettype none

module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  fmt_e            w_fmt;
  logic [XLEN-1:0] w_imm;
  logic            w_illegal;
  decoded_t        w_dec;
  logic            w_accept;

  decoded_t        r_bundle;
  logic [XLEN-1:0] r_imm;
  logic [PC_W-1:0] r_pc;
  logic            r_valid;

  rv_imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .instr   (in_instr),
    .fmt     (w_fmt),
    .imm     (w_imm),
    .illegal (w_illegal)
  );

  always_comb begin
    w_dec.opcode  = in_instr[6:0];
    w_dec.rd      = in_instr[11:7];
    w_dec.funct3  = in_instr[14:12];
    w_dec.rs1     = in_instr[19:15];
    w_dec.rs2     = in_instr[24:20];
    w_dec.funct7  = in_instr[31:25];
    w_dec.fmt     = w_fmt;
    w_dec.illegal = w_illegal;
  end

  assign w_accept = in_valid && in_ready;

`ifdef RV_DECODE_SKID_EN
  decoded_t        r_skid;
  logic [XLEN-1:0] r_skid_imm;
  logic [PC_W-1:0] r_skid_pc;
  logic            r_skid_valid;
  logic            w_out_free;

  // in_ready is a flop output: accept whenever the skid slot is empty.
  assign in_ready   = !r_skid_valid;
  assign w_out_free = !r_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_bundle     <= '0;
      r_imm        <= '0;
      r_pc         <= '0;
      r_skid_valid <= 1'b0;
      r_skid       <= '0;
      r_skid_imm   <= '0;
      r_skid_pc    <= '0;
    end else if (flush) begin
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_valid      <= 1'b1;
        r_bundle     <= r_skid;
        r_imm        <= r_skid_imm;
        r_pc         <= r_skid_pc;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid  <= 1'b1;
        r_bundle <= w_dec;
        r_imm    <= w_imm;
        r_pc     <= in_pc;
      end else begin
        r_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid       <= w_dec;
      r_skid_imm   <= w_imm;
      r_skid_pc    <= in_pc;
    end
  end
`else
  assign in_ready = !r_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_bundle <= '0;
      r_imm    <= '0;
      r_pc     <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_bundle <= w_dec;
      r_imm    <= w_imm;
      r_pc     <= in_pc;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end
`endif

  assign out_valid = r_valid;
  assign out_pc    = r_pc;
  assign opcode    = r_bundle.opcode;
  assign rd        = r_bundle.rd;
  assign funct3    = r_bundle.funct3;
  assign rs1       = r_bundle.rs1;
  assign rs2       = r_bundle.rs2;
  assign funct7    = r_bundle.funct7;
  assign imm       = r_imm;
  assign fmt       = r_bundle.fmt;
  assign illegal   = r_bundle.illegal;

endmodule

`default_nettype wire

// File: tb/tb_rv_decode_stage.sv
// ============================================================================
// tb_rv_decode_stage: randomized + directed bench with a behavioural decode model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rv_decode_stage;

  localparam int XLEN = 32;
  localparam int PC_W = 32;
  localparam int ALLW = PC_W + 7 + 5 + 3 + 5 + 5 + 7 + XLEN + 3 + 1 + 1;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, out_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            in_ready, out_valid, illegal;
  logic [PC_W-1:0] out_pc;
  logic [6:0]      opcode, funct7;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      funct3, fmt;
  logic [XLEN-1:0] imm;

  logic            in_ready64, out_valid64, illegal64;
  logic [PC_W-1:0] out_pc64;
  logic [6:0]      opcode64, funct7_64;
  logic [4:0]      rd64, rs1_64, rs2_64;
  logic [2:0]      funct3_64, fmt64;
  logic [63:0]     imm64;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
  } item_t;
  item_t exp_q[$];

  logic [6:0] legal_ops [11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                                 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};

  always #5 clk = ~clk;

  rv_decode_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm), .fmt(fmt), .illegal(illegal)
  );

  rv_decode_stage #(.XLEN(64), .PC_W(PC_W)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid64), .out_ready(out_ready),
    .out_pc(out_pc64), .opcode(opcode64), .rd(rd64), .funct3(funct3_64), .rs1(rs1_64),
    .rs2(rs2_64), .funct7(funct7_64), .imm(imm64), .fmt(fmt64), .illegal(illegal64)
  );

  // Reference decode computed arithmetically from the field definitions.
  function automatic void ref_dec(input logic [31:0] ins, output int f,
                                  output longint im, output bit ill);
    longint s;
    s   = longint'($signed(ins));
    f   = 0;
    im  = 0;
    ill = 0;
    if (ins[1:0] != 2'b11) ill = 1;
    else case (ins[6:0])
      7'h33: f = 0;
      7'h03, 7'h13, 7'h67, 7'h73, 7'h0F: begin f = 1; im = s >>> 20; end
      7'h23: begin f = 2; im = (s >>> 25) * 32 + longint'(ins[11:7]); end
      7'h63: begin
        f  = 3;
        im = (ins[31] ? -64'sd4096 : 64'sd0) + longint'(ins[7]) * 2048
           + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
      end
      7'h37, 7'h17: begin f = 4; im = s - longint'(ins[11:0]); end
      7'h6F: begin
        f  = 5;
        im = (ins[31] ? -64'sd1048576 : 64'sd0) + longint'(ins[19:12]) * 4096
           + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
      end
      default: ill = 1;
    endcase
    if (ill) begin f = 0; im = 0; end
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(7) != 0) r[6:0] = legal_ops[$urandom_range(10)];
    return r;
  endfunction

  // Scoreboard monitor: tracks accepted instructions and checks every cycle.
  logic [ALLW-1:0] cur_all, snap;
  bit              prev_stall = 0;
  assign cur_all = {out_pc, opcode, rd, funct3, rs1, rs2, funct7, imm, fmt, illegal, out_valid};

  always @(negedge clk) begin
    int f; longint im; bit ill;
    logic [31:0] ei; logic [31:0] ins;
    if (rst) begin
      exp_q.delete();
      prev_stall = 0;
    end else begin
      n_cmp++;
      if (out_valid !== (exp_q.size() != 0)) begin
        n_err++;
        $display("FAIL mon_out_valid: got %b want %b", out_valid, exp_q.size() != 0);
      end
      n_cmp++;
`ifdef RV_DECODE_SKID_EN
      if (in_ready !== (exp_q.size() < 2)) begin
        n_err++;
        $display("FAIL mon_in_ready: got %b want %b", in_ready, exp_q.size() < 2);
      end
`else
      if (in_ready !== (!out_valid || out_ready)) begin
        n_err++;
        $display("FAIL mon_in_ready: got %b want %b", in_ready, !out_valid || out_ready);
      end
`endif
      if (prev_stall) begin
        n_cmp++;
        if (cur_all !== snap) begin
          n_err++;
          $display("FAIL mon_stall_hold: got %h want %h", cur_all, snap);
        end
      end
      if (out_valid && exp_q.size() != 0) begin
        ins = exp_q[0].instr;
        ref_dec(ins, f, im, ill);
        ei = im[31:0];
        n_cmp++;
        if ({opcode, rd, funct3, rs1, rs2, funct7, fmt, illegal} !==
            {ins[6:0], ins[11:7], ins[14:12], ins[19:15], ins[24:20], ins[31:25], 3'(f), ill}) begin
          n_err++;
          $display("FAIL mon_fields instr=%h: got op=%h rd=%0d f3=%0d rs1=%0d rs2=%0d f7=%h fmt=%0d ill=%b want fmt=%0d ill=%b",
                   ins, opcode, rd, funct3, rs1, rs2, funct7, fmt, illegal, f, ill);
        end
        n_cmp++;
        if (imm !== ei) begin
          n_err++;
          $display("FAIL mon_imm instr=%h: got %h want %h", ins, imm, ei);
        end
        n_cmp++;
        if (imm64 !== im) begin
          n_err++;
          $display("FAIL mon_imm64 instr=%h: got %h want %h", ins, imm64, im);
        end
        n_cmp++;
        if (out_pc !== exp_q[0].pc) begin
          n_err++;
          $display("FAIL mon_pc: got %h want %h", out_pc, exp_q[0].pc);
        end
      end
      snap       = cur_all;
      prev_stall = out_valid && !out_ready && !flush;
      if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back('{instr: in_instr, pc: in_pc});
    end
  end

  task automatic idle(input int n);
    in_valid = 0; flush = 0; out_ready = 1;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    rst = 1; in_valid = 1; in_instr = 32'h00500093; in_pc = 32'h100;
    out_ready = 1; flush = 0;
    repeat (3) @(posedge clk);
    #2;
    rst = 0; in_valid = 0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    n_cmp++;
    if ({out_pc, opcode, rd, funct3, rs1, rs2, funct7, imm, fmt, illegal} !== '0) begin
      n_err++; $display("FAIL reset_fields: got %h want 0",
                        {out_pc, opcode, rd, funct3, rs1, rs2, funct7, imm, fmt, illegal});
    end
    idle(2);
  endtask

  task automatic test_directed;
    logic [31:0] t_ins [6] = '{32'h00500093, 32'hFE20AE23, 32'hFE000CE3,
                                32'h123452B7, 32'h00000000, 32'h0000007F};
    logic [30:0] t_fld [6] = '{{7'h13, 5'd1, 3'd0, 5'd0, 5'd5, 3'd1, 1'b0},
                               {7'h23, 5'd28, 3'd2, 5'd1, 5'd2, 3'd2, 1'b0},
                               {7'h63, 5'd25, 3'd0, 5'd0, 5'd0, 3'd3, 1'b0},
                               {7'h37, 5'd5, 3'd5, 5'd8, 5'd3, 3'd4, 1'b0},
                               {7'h00, 5'd0, 3'd0, 5'd0, 5'd0, 3'd0, 1'b1},
                               {7'h7F, 5'd0, 3'd0, 5'd0, 5'd0, 3'd0, 1'b1}};
    logic [63:0] t_imm [6] = '{64'd5, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF8,
                               64'h1234_5000, 64'd0, 64'd0};
    logic [PC_W-1:0] pc;
    logic [63:0]     e64;
    for (int i = 0; i < 6; i++) begin
      pc = $urandom;
      e64 = t_imm[i];
      in_valid = 1; in_instr = t_ins[i]; in_pc = pc; out_ready = 1; flush = 0;
      @(posedge clk); #2;
      in_valid = 0;
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_err++; $display("FAIL dir_valid[%0d]: got %b want 1", i, out_valid);
      end
      n_cmp++;
      if ({opcode, rd, funct3, rs1, rs2, fmt, illegal} !== t_fld[i]) begin
        n_err++; $display("FAIL dir_fields[%0d]: got %h want %h", i,
                          {opcode, rd, funct3, rs1, rs2, fmt, illegal}, t_fld[i]);
      end
      n_cmp++;
      if (imm !== e64[31:0]) begin
        n_err++; $display("FAIL dir_imm[%0d]: got %h want %h", i, imm, e64[31:0]);
      end
      n_cmp++;
      if (imm64 !== e64) begin
        n_err++; $display("FAIL dir_imm64[%0d]: got %h want %h", i, imm64, e64);
      end
      n_cmp++;
      if (out_pc !== pc) begin
        n_err++; $display("FAIL dir_pc[%0d]: got %h want %h", i, out_pc, pc);
      end
    end
    idle(2);
  endtask

  task automatic test_ready_path;
    logic r0, r1;
    in_valid = 1; in_instr = rnd_instr(); in_pc = $urandom; out_ready = 0;
    @(posedge clk); #2;
    in_valid = 0;
    out_ready = 0; #1 r0 = in_ready;
    out_ready = 1; #1 r1 = in_ready;
    out_ready = 0;
`ifdef RV_DECODE_SKID_EN
    n_cmp++;
    if (r0 !== r1) begin
      n_err++; $display("FAIL ready_comb_path: got %b/%b want equal", r0, r1);
    end
`else
    n_cmp++;
    if ({r0, r1} !== 2'b01) begin
      n_err++; $display("FAIL ready_base: got %b%b want 01", r0, r1);
    end
`endif
    idle(3);
  endtask

  task automatic test_stream;
    logic [31:0] s [8];
    int idx = 0, n_out = 0, cyc = 0;
    for (int i = 0; i < 8; i++) s[i] = rnd_instr();
    while (n_out < 8 && cyc < 60) begin
      in_valid  = (idx < 8);
      in_instr  = s[idx % 8];
      in_pc     = 32'h1000 + 4 * idx;
      out_ready = !(cyc >= 4 && cyc < 7);
      flush     = 0;
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) n_out++;
      cyc++;
      @(posedge clk); #2;
    end
    in_valid = 0;
    n_cmp++;
    if (n_out !== 8 || idx !== 8) begin
      n_err++; $display("FAIL stream_count: got out=%0d in=%0d want 8/8", n_out, idx);
    end
    idle(2);
  endtask

  task automatic test_flush;
    in_valid = 1; in_instr = 32'h00500093; in_pc = 32'h40; out_ready = 0; flush = 0;
    @(posedge clk); #2;
    in_instr = 32'h123452B7; flush = 1;
    @(posedge clk); #2;
    flush = 0; in_valid = 0; out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL flush_held[%0d]: got %b want 0", i, out_valid);
      end
      @(posedge clk); #2;
    end
    in_valid = 1; in_instr = 32'hFE000CE3; flush = 1;
    @(posedge clk); #2;
    in_valid = 0; flush = 0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_accept: got %b want 0", out_valid);
    end
    idle(2);
  endtask

  task automatic test_reset_midstall;
    in_valid = 1; in_instr = rnd_instr(); in_pc = $urandom; out_ready = 0;
    @(posedge clk); #2;
    in_instr = rnd_instr();
    @(posedge clk); #2;
    rst = 1;
    @(posedge clk); #2;
    rst = 0; in_valid = 0;
    n_cmp++;
    if (cur_all !== '0) begin
      n_err++; $display("FAIL reset_midstall: got %h want 0", cur_all);
    end
    idle(2);
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_instr  = rnd_instr();
      in_pc     = $urandom;
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(19) == 0);
      @(posedge clk); #2;
    end
    idle(4);
  endtask

  initial begin
    rst = 1; flush = 0; in_valid = 0; out_ready = 1; in_instr = '0; in_pc = '0;
    test_reset();
    test_directed();
    test_ready_path();
    test_stream();
    test_flush();
    test_reset_midstall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
